sub_bytes_seq: RTL and testbench

- Substitution stage directly upstream of the diffusion stage.
- Accepts a 4x4 byte state and replaces each byte with its FIPS-197 AES S-box value, LANES bytes per clock.
- Uses a time-multiplexed, area-reduced S-box datapath and presents the finished state, held stable, to diffusion_in of the diffusion stage.
- Valid/ready handshakes on both sides; single state buffer.

---
 rtl/sub_bytes_seq.sv | 142 ++++++++++++++
 tb/tb_sub_bytes_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: sequential AES SubBytes stage.
// Captures a 4x4 byte state, substitutes LANES bytes per clock through LANES
// S-box lookups, then holds the finished state on sub_out for the diffusion
// stage until it is consumed. sub_out is the working register itself.
module sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][3:0][7:0]  sub_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][7:0]  sub_out,
    output logic                  busy
);

    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Forward AES S-box, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX_LUT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_LUT[x];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    // Flat view of the state: byte k = 4*row + col sits at bits [8k+7:8k].
    logic [127:0]      work_q;
    logic [127:0]      work_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [3:0]        lane_k   [LANES];
    logic [7:0]        lane_out [LANES];

    // One S-box per lane; lane l works on linear byte cnt*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_k[l]   = 4'(int'(cnt_q) * LANES + l);
        assign lane_out[l] = sbox(work_q[8*lane_k[l] +: 8]);
    end

    // Merge this step's substituted bytes into a copy of the working register.
    always_comb begin
        // NOTE: work_d gets a full default before any partial overwrite, so no latch is inferred.
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[8*lane_k[l] +: 8] = lane_out[l];
        end
    end

    // Control FSM with registered handshake outputs and the working register.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            // NOTE: the working register is reset because it drives sub_out directly and must read 00 after reset.
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= sub_in;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sub_out   = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: three instances (LANES = 1, 4, 16) share
// inputs; most scenarios observe the LANES=1 instance, the lanes scenario all three.
module tb_sub_bytes_seq;

    typedef logic [3:0][3:0][7:0] blk_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    blk_t sub_in;

    logic in_ready_v  [3];
    logic out_valid_v [3];
    logic busy_v      [3];
    blk_t sub_out_v   [3];

    int n_cmp = 0;
    int n_bad = 0;

    blk_t data1, exp1, data2, exp2, data3, exp3, mid1;

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .sub_in(sub_in), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .sub_out(sub_out_v[0]), .busy(busy_v[0])
    );

    sub_bytes_seq #(.LANES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .sub_in(sub_in), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .sub_out(sub_out_v[1]), .busy(busy_v[1])
    );

    sub_bytes_seq #(.LANES(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .sub_in(sub_in), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .sub_out(sub_out_v[2]), .busy(busy_v[2])
    );

    function automatic int steps_of(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] flags(input int d);
        return {in_ready_v[d], out_valid_v[d], busy_v[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sub_in    = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sub_in    = data1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({flags(d), sub_out_v[d]} !== {3'b100, 128'h0}) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got flags %b out %h want flags 100 out 0", d, flags(d), sub_out_v[d]);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (flags(0) !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_release: got flags %b want 100", flags(0));
        end
    endtask

    task automatic test_basic();
        do_reset();
        sub_in   = data1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sub_in   = {16{8'ha5}};
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (flags(0) !== 3'b001) begin
                n_bad++;
                $display("FAIL basic_busy[%0d]: got flags %b want 001", i, flags(0));
            end
            if (i == 3) begin
                n_cmp++;
                if (sub_out_v[0] !== mid1) begin
                    n_bad++;
                    $display("FAIL basic_partial: got %h want %h", sub_out_v[0], mid1);
                end
            end
            tick();
        end
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b010, exp1}) begin
            n_bad++;
            $display("FAIL basic_done: got flags %b out %h want 010 %h", flags(0), sub_out_v[0], exp1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({flags(0), sub_out_v[0]} !== {3'b010, exp1}) begin
                n_bad++;
                $display("FAIL basic_hold[%0d]: got flags %b out %h want 010 %h", i, flags(0), sub_out_v[0], exp1);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (flags(0) !== 3'b100) begin
            n_bad++;
            $display("FAIL basic_release: got flags %b want 100", flags(0));
        end
    endtask

    task automatic test_ready_tied();
        int n;
        do_reset();
        out_ready = 1'b1;
        sub_in    = data2;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid_v[0] && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if ({n, sub_out_v[0]} !== {32'd16, exp2}) begin
            n_bad++;
            $display("FAIL tied_latency: got %0d edges out %h want 16 edges %h", n, sub_out_v[0], exp2);
        end
        tick();
        n_cmp++;
        if (flags(0) !== 3'b100) begin
            n_bad++;
            $display("FAIL tied_one_cycle: got flags %b want 100", flags(0));
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        sub_in   = data1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_v[0] && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (out_valid_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_wait: out_valid never rose within 40 cycles");
        end
        sub_in   = data2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({flags(0), sub_out_v[0]} !== {3'b010, exp1}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got flags %b out %h want 010 %h", i, flags(0), sub_out_v[0], exp1);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b100, exp1}) begin
            n_bad++;
            $display("FAIL bp_release: got flags %b out %h want 100 %h", flags(0), sub_out_v[0], exp1);
        end
        tick();
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b001, data2}) begin
            n_bad++;
            $display("FAIL bp_accept2: got flags %b out %h want 001 %h", flags(0), sub_out_v[0], data2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b010, exp2}) begin
            n_bad++;
            $display("FAIL bp_second: got flags %b out %h want 010 %h", flags(0), sub_out_v[0], exp2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sub_in   = data1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        sub_in   = data3;
        tick();
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b100, 128'h0}) begin
            n_bad++;
            $display("FAIL mid_reset: got flags %b out %h want 100 0", flags(0), sub_out_v[0]);
        end
        tick();
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b100, 128'h0}) begin
            n_bad++;
            $display("FAIL mid_reset_no_capture: got flags %b out %h want 100 0", flags(0), sub_out_v[0]);
        end
        reset  = 1'b0;
        sub_in = data2;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (flags(0) !== 3'b001) begin
            n_bad++;
            $display("FAIL mid_fresh_accept: got flags %b want 001", flags(0));
        end
        for (int i = 0; i < 16; i++) tick();
        n_cmp++;
        if ({flags(0), sub_out_v[0]} !== {3'b010, exp2}) begin
            n_bad++;
            $display("FAIL mid_fresh_done: got flags %b out %h want 010 %h", flags(0), sub_out_v[0], exp2);
        end
    endtask

    task automatic test_lanes();
        do_reset();
        sub_in   = data1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 18; t++) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (t < steps_of(d)) begin
                    if (flags(d) !== 3'b001) begin
                        n_bad++;
                        $display("FAIL lanes_busy[%0d][t=%0d]: got flags %b want 001", d, t, flags(d));
                    end
                end else begin
                    if ({flags(d), sub_out_v[d]} !== {3'b010, exp1}) begin
                        n_bad++;
                        $display("FAIL lanes_done[%0d][t=%0d]: got flags %b out %h want 010 %h", d, t, flags(d), sub_out_v[d], exp1);
                    end
                end
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (flags(d) !== 3'b100) begin
                n_bad++;
                $display("FAIL lanes_release[%0d]: got flags %b want 100", d, flags(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        blk_t vin  [3];
        blk_t vexp [3];
        int   n_sent, n_recv, cyc, last_out, extra;
        logic will_accept;
        vin[0] = data1; vin[1] = data2; vin[2] = data3;
        vexp[0] = exp1; vexp[1] = exp2; vexp[2] = exp3;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sub_in    = vin[0];
        n_sent = 0; n_recv = 0; cyc = 0; last_out = 0;
        while (n_recv < 3 && cyc < 200) begin
            will_accept = in_ready_v[0] && in_valid;
            tick();
            cyc++;
            if (will_accept) begin
                n_sent++;
                if (n_sent < 3) sub_in = vin[n_sent];
                else            in_valid = 1'b0;
            end
            if (out_valid_v[0]) begin
                n_cmp++;
                if (sub_out_v[0] !== vexp[n_recv]) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", n_recv, sub_out_v[0], vexp[n_recv]);
                end
                if (n_recv > 0) begin
                    n_cmp++;
                    if (cyc - last_out !== 18) begin
                        n_bad++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles want 18", n_recv, cyc - last_out);
                    end
                end
                last_out = cyc;
                n_recv++;
            end
        end
        n_cmp++;
        if (n_recv !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d outputs want 3 within 200 cycles", n_recv);
        end
        in_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid_v[0]) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL b2b_duplicate: got %0d extra outputs want 0", extra);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        data1 = {{4{8'h01}}, {4{8'h02}}, {4{8'h03}}, {4{8'h04}}};
        exp1  = {{4{8'h7c}}, {4{8'h77}}, {4{8'h7b}}, {4{8'hf2}}};
        mid1  = data1;
        mid1[0][0] = 8'hf2;
        mid1[0][1] = 8'hf2;
        mid1[0][2] = 8'hf2;
        data2 = '0;
        data2[1][2] = 8'h53;
        data2[3][3] = 8'hff;
        exp2  = {16{8'h63}};
        exp2[1][2] = 8'hed;
        exp2[3][3] = 8'h16;
        data3 = {16{8'h53}};
        exp3  = {16{8'hed}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sub_in    = '0;

        test_reset();
        test_basic();
        test_ready_tied();
        test_backpressure();
        test_reset_mid();
        test_lanes();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
